vga_timing: RTL and testbench

- Pixel-rate raster generator sitting directly upstream of the test-pattern generator and any other pixel-source stage.
- Produces the horizontal and vertical pixel coordinates, the active-video data enable, the sync pulses to the VGA connector, and line and frame markers.
- Default timing is 640x480 at 60 Hz from a ~25.175 MHz pixel clock.
- All outputs are registered and mutually aligned, so downstream stages see hcount, vcount and de on the same cycle as the matching hsync and vsync.

---
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_timing.sv | 100 ++++++++++
 tb/tb_vga_timing.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing bundle from vga_timing to pixel-source stages
interface vga_timing_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic       vblank;
  logic [7:0] frame_count;

  modport master (
    output hcount, vcount, de, hsync, vsync,
           line_start, frame_start, vblank, frame_count
  );

  modport slave (
    input  hcount, vcount, de, hsync, vsync,
           line_start, frame_start, vblank, frame_count
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-rate raster generator with aligned syncs, de and frame markers
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic          clk_pix,
  input  logic          reset,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Thresholds carry an extra bit so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON    = (HS_POL != 0);
  localparam logic        VS_ON    = (VS_POL != 0);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_q, vblank_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [10:0] h_ext, v_ext;

  // Outputs are decoded from the next counter state so they land on the same edge as the counters.
  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q >= H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q >= V_LAST) ? '0 : vcount_q + 10'd1;
    end

    h_ext = {1'b0, hcount_d};
    v_ext = {1'b0, vcount_d};

    de_d          = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
    hsync_d       = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HS_ON : !HS_ON;
    vsync_d       = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VS_ON : !VS_ON;
    vblank_d      = (v_ext >= V_ACT_E);
    line_start_d  = (hcount_d == 10'd0);
    frame_start_d = line_start_d && (vcount_d == 10'd0);
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= !HS_ON;
      vsync_q       <= !VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b1;
      frame_count_q <= 8'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.de          = de_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.vblank      = vblank_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing, default and small alternate timing
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic       vb;
    logic [7:0] fc;
  } vo_t;

  typedef struct {
    int  t;
    vo_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_a = 1'b1;
  int   t_d = -1;
  int   t_a = -1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_timing_if vif_d ();
  vga_timing_if vif_a ();

  vga_timing dut_d (
    .clk_pix (clk),
    .reset   (rst_d),
    .vga     (vif_d)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) dut_a (
    .clk_pix (clk),
    .reset   (rst_a),
    .vga     (vif_a)
  );

  // Raster position is a pure function of cycles elapsed since reset release.
  function automatic vo_t model(int t, int ha, int hf, int hsw, int hb,
                                int va, int vf, int vsw, int vbp, int hpol, int vpol);
    vo_t r;
    int ht, vt, h, v, fr;
    logic hp, vp;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vbp;
    hp = (hpol != 0);
    vp = (vpol != 0);
    if (t < 0) begin
      r.h = 10'(ht - 1); r.v = 10'(vt - 1);
      r.de = 1'b0; r.hs = !hp; r.vs = !vp;
      r.ls = 1'b0; r.fs = 1'b0; r.vb = 1'b1; r.fc = 8'd0;
      return r;
    end
    h  = t % ht;
    v  = (t / ht) % vt;
    fr = t / (ht * vt);
    r.h  = 10'(h);
    r.v  = 10'(v);
    r.de = (h < ha) && (v < va);
    r.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    r.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    r.vb = (v >= va);
    r.fc = 8'((fr + 1) % 256);
    return r;
  endfunction

  function automatic vo_t exp_d(int t);
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
  endfunction

  function automatic vo_t exp_a(int t);
    return model(t, 8, 2, 3, 1, 4, 1, 1, 1, 1, 1);
  endfunction

  function automatic vo_t get_d();
    vo_t r;
    r.h = vif_d.hcount; r.v = vif_d.vcount; r.de = vif_d.de;
    r.hs = vif_d.hsync; r.vs = vif_d.vsync; r.ls = vif_d.line_start;
    r.fs = vif_d.frame_start; r.vb = vif_d.vblank; r.fc = vif_d.frame_count;
    return r;
  endfunction

  function automatic vo_t get_a();
    vo_t r;
    r.h = vif_a.hcount; r.v = vif_a.vcount; r.de = vif_a.de;
    r.hs = vif_a.hsync; r.vs = vif_a.vsync; r.ls = vif_a.line_start;
    r.fs = vif_a.frame_start; r.vb = vif_a.vblank; r.fc = vif_a.frame_count;
    return r;
  endfunction

  function automatic vec_t mk(int t, int h, int v, bit de, bit hs, bit vs,
                              bit ls, bit fs, bit vb, int fc);
    vec_t r;
    r.t = t;
    r.e.h = 10'(h); r.e.v = 10'(v); r.e.de = de; r.e.hs = hs; r.e.vs = vs;
    r.e.ls = ls; r.e.fs = fs; r.e.vb = vb; r.e.fc = 8'(fc);
    return r;
  endfunction

  task automatic cmp(string name, vo_t act, vo_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d, want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d",
               name, act.h, act.v, act.de, act.hs, act.vs, act.ls, act.fs, act.vb, act.fc,
               exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.vb, exp.fc);
    end
  endtask

  task automatic cmp_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic rd, ra;
    rd = rst_d;
    ra = rst_a;
    @(posedge clk);
    t_d = rd ? -1 : t_d + 1;
    t_a = ra ? -1 : t_a + 1;
    #1;
    cmp("def_cycle", get_d(), exp_d(t_d));
    cmp("alt_cycle", get_a(), exp_a(t_a));
  endtask

  initial begin
    vec_t tbl[$];
    int   bound;
    int   n_de, n_hs, n_vs, n_ls, n_fs, last_fs, gap_bad;
    int   dn_de, dn_hs, dn_ls;
    logic [9:0] prev_h;

    tbl.push_back(mk( 0,  0, 0, 1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk( 7,  7, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk( 8,  8, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(10, 10, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(12, 12, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(13, 13, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(14,  0, 1, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(56,  0, 4, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(70,  0, 5, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(80, 10, 5, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(84,  0, 6, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(97, 13, 6, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(98,  0, 0, 1, 0, 0, 1, 1, 0, 2));

    // Reset held for five cycles, then released on both instances.
    repeat (5) step();
    cmp("def_in_reset", get_d(), mk(0, 799, 524, 0, 1, 1, 0, 0, 1, 0).e);
    rst_d = 1'b0;
    rst_a = 1'b0;
    step();
    cmp("def_first", get_d(), mk(0, 0, 0, 1, 1, 1, 1, 1, 0, 1).e);

    foreach (tbl[i]) begin
      bound = 0;
      while (t_a < tbl[i].t && bound < 1000) begin
        step();
        bound++;
      end
      cmp($sformatf("alt_tbl_t%0d", tbl[i].t), get_a(), tbl[i].e);
    end

    // One full default line: de, hsync and line_start occupancy plus the 799->0 wrap.
    bound = 0;
    while (t_d < 799 && bound < 2000) begin step(); bound++; end
    dn_de = 0; dn_hs = 0; dn_ls = 0;
    for (int i = 0; i < 800; i++) begin
      prev_h = vif_d.hcount;
      step();
      if (vif_d.de) dn_de++;
      if (!vif_d.hsync) dn_hs++;
      if (vif_d.line_start) dn_ls++;
      if (i == 0) begin
        cmp_int("def_wrap_prev_h", int'(prev_h), 799);
        cmp_int("def_wrap_v", int'(vif_d.vcount), 1);
      end
    end
    cmp_int("def_line_de", dn_de, 640);
    cmp_int("def_line_hsync", dn_hs, 96);
    cmp_int("def_line_ls", dn_ls, 1);

    // Reset inside the default hsync pulse.
    bound = 0;
    while (t_d % 800 != 700 && bound < 1000) begin step(); bound++; end
    cmp_int("def_pre_rst_hsync", int'(vif_d.hsync), 0);
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    cmp("def_mid_rst", get_d(), mk(0, 799, 524, 0, 1, 1, 0, 0, 1, 0).e);

    // Reset inside both alternate sync windows.
    bound = 0;
    while (t_a % 98 != 81 && bound < 200) begin step(); bound++; end
    cmp("alt_pre_rst", get_a(), mk(0, 11, 5, 0, 1, 1, 0, 0, 1, (t_a / 98 + 1) % 256).e);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cmp("alt_mid_rst", get_a(), mk(0, 13, 6, 0, 0, 0, 0, 0, 1, 0).e);
    step();
    cmp("alt_restart", get_a(), mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1).e);

    // Two alternate frames: occupancy counts and frame_start spacing.
    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; last_fs = 0; gap_bad = 0;
    for (int i = 1; i <= 196; i++) begin
      if (vif_a.de) n_de++;
      if (vif_a.hsync) n_hs++;
      if (vif_a.vsync) n_vs++;
      if (vif_a.line_start) n_ls++;
      if (vif_a.frame_start) begin
        n_fs++;
        if (i > 1 && (t_a - last_fs) != 98) gap_bad++;
        last_fs = t_a;
      end
      step();
    end
    cmp_int("alt_de_2fr", n_de, 64);
    cmp_int("alt_hsync_2fr", n_hs, 42);
    cmp_int("alt_vsync_2fr", n_vs, 28);
    cmp_int("alt_ls_2fr", n_ls, 14);
    cmp_int("alt_fs_2fr", n_fs, 2);
    cmp_int("alt_fs_gap", gap_bad, 0);

    // frame_count wrap 255 -> 0 on the alternate instance.
    bound = 0;
    while (t_a < 254 * 98 && bound < 30000) begin step(); bound++; end
    cmp_int("alt_fc_255", int'(vif_a.frame_count), 255);
    bound = 0;
    while (t_a < 255 * 98 && bound < 200) begin step(); bound++; end
    cmp_int("alt_fc_wrap", int'(vif_a.frame_count), 0);
    cmp_int("alt_fc_wrap_fs", int'(vif_a.frame_start), 1);

    // Random reset pulses on either instance at random raster positions.
    for (int k = 0; k < 20; k++) begin
      int gap, len, which;
      gap   = int'($urandom_range(0, 300));
      len   = int'($urandom_range(1, 4));
      which = int'($urandom_range(0, 1));
      repeat (gap) step();
      if (which == 0) rst_d = 1'b1; else rst_a = 1'b1;
      repeat (len) step();
      rst_d = 1'b0;
      rst_a = 1'b0;
      repeat (3) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
